// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: prefetch queue entry layout and
// the per-half parcel valid encodings presented to the fetch stage.
package riscv_pkg;

    localparam int XLEN = 32;

    // Both 16-bit halves valid (word-aligned PC) / only the upper half (pc[1]=1)
    localparam logic [1:0] PFQ_VALID_FULL = 2'b11;
    localparam logic [1:0] PFQ_VALID_HI   = 2'b10;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            misaligned;
        logic            page_fault;
    } if_pfq_entry_t;

endpackage

// File: rtl/riscv_pfq_fifo.sv
// Small synchronous FIFO used for the prefetch entry queue and the PC tag
// queue. The head is read straight from the storage array, so a push is
// visible on the cycle after it is written and a pop exposes the next entry
// on the cycle after the pointer moves. Flush empties the FIFO and takes
// priority over push/pop in the same cycle.
module riscv_pfq_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] occ,
    output logic [WIDTH-1:0]       head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      occ_reg;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (occ_reg == '0);
    assign full    = (occ_reg == (AW+1)'(DEPTH));
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign occ     = occ_reg;
    assign head    = mem[rd_ptr_reg];

    // Storage write; no reset so the array maps onto plain RAM/LUT storage
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers wrap modulo DEPTH; occupancy tracks push/pop balance
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            occ_reg    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            occ_reg <= occ_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Credit accounting upstream must make a push into a full FIFO impossible
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && full && !flush));
        end
    end

endmodule

// File: rtl/riscv_if_prefetch.sv
// Instruction prefetch queue between a pipelined req/gnt/rvalid instruction
// bus and the core fetch stage. Holds the credit, discard and issue logic;
// returned words are paired with their PC from a tag FIFO and queued.
module riscv_if_prefetch #(
    parameter int XLEN        = 32,
    parameter int PARCEL_SIZE = 32,
    parameter int DEPTH       = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [XLEN-1:0]        if_nxt_pc,
    output logic                   if_stall_nxt_pc,
    input  logic                   if_stall,
    input  logic                   if_flush,
    output logic [PARCEL_SIZE-1:0] if_parcel,
    output logic [XLEN-1:0]        if_parcel_pc,
    output logic [1:0]             if_parcel_valid,
    output logic                   if_parcel_misaligned,
    output logic                   if_parcel_page_fault,
    output logic                   imem_req,
    output logic [XLEN-1:0]        imem_adr,
    input  logic                   imem_gnt,
    input  logic                   imem_rvalid,
    input  logic [XLEN-1:0]        imem_rdata,
    input  logic                   imem_err
);

    import riscv_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;
    // Sums of two counters need one extra bit before comparing with DEPTH
    localparam logic [CW:0] DEPTH_S = (CW+1)'(DEPTH);

    if_pfq_entry_t   q_push_data;
    if_pfq_entry_t   q_head;
    logic [CW-1:0]   q_occ;
    logic [CW-1:0]   tag_occ;
    logic [XLEN-1:0] tag_head;
    logic [CW-1:0]   outstanding_reg, outstanding_next;
    logic [CW-1:0]   discard_reg, discard_next;
    logic            can_issue;
    logic            bus_accept;
    logic            mis_accept;
    logic            tag_pop;
    logic            resp_keep;
    logic            q_push;
    logic            q_pop;

    // Entry queue credit covers words already queued plus words in flight;
    // tag FIFO credit covers live requests plus responses still to be dropped.
    assign can_issue = (({1'b0, q_occ} + {1'b0, outstanding_reg}) < DEPTH_S)
                     & (({1'b0, outstanding_reg} + {1'b0, discard_reg}) < DEPTH_S)
                     & ~if_flush & ~rst;

    assign imem_req        = can_issue & ~if_nxt_pc[0];
    assign imem_adr        = {if_nxt_pc[XLEN-1:2], 2'b00};
    assign bus_accept      = imem_req & imem_gnt;
    // An odd PC never reaches the bus; it becomes a fault entry once no
    // earlier fetch can still land ahead of it.
    assign mis_accept      = can_issue & if_nxt_pc[0] & (outstanding_reg == '0);
    assign if_stall_nxt_pc = ~(bus_accept | mis_accept);

    // Every response with a request behind it retires one tag, kept or not
    assign tag_pop   = imem_rvalid & (tag_occ != '0);
    assign resp_keep = imem_rvalid & (discard_reg == '0) & (outstanding_reg != '0) & ~if_flush;
    assign q_push    = resp_keep | mis_accept;
    assign q_pop     = (q_occ != '0) & ~if_stall;

    // Queue entry source: a kept bus response, otherwise a misaligned fault
    always_comb begin
        q_push_data = '0;
        if (resp_keep) begin
            q_push_data.pc         = tag_head;
            q_push_data.instr      = imem_rdata;
            q_push_data.page_fault = imem_err;
        end else begin
            q_push_data.pc         = if_nxt_pc;
            q_push_data.misaligned = 1'b1;
        end
    end

    // Outstanding/discard bookkeeping; flush turns live requests into discards
    always_comb begin
        outstanding_next = outstanding_reg;
        discard_next     = discard_reg;
        if (if_flush) begin
            outstanding_next = '0;
            discard_next     = discard_reg + outstanding_reg - CW'(tag_pop);
        end else begin
            outstanding_next = outstanding_reg + CW'(bus_accept) - CW'(resp_keep);
            if (tag_pop && (discard_reg != '0)) begin
                discard_next = discard_reg - CW'(1);
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding_reg <= '0;
            discard_reg     <= '0;
        end else begin
            outstanding_reg <= outstanding_next;
            discard_reg     <= discard_next;
        end
    end

    riscv_pfq_fifo #(
        .WIDTH ($bits(if_pfq_entry_t)),
        .DEPTH (DEPTH)
    ) u_entry_q (
        .clk       (clk),
        .rst       (rst),
        .push      (q_push),
        .push_data (q_push_data),
        .pop       (q_pop),
        .flush     (if_flush),
        .occ       (q_occ),
        .head      (q_head)
    );

    // Tag entries survive a flush: they still pair with the discarded responses
    riscv_pfq_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_tag_q (
        .clk       (clk),
        .rst       (rst),
        .push      (bus_accept),
        .push_data (if_nxt_pc),
        .pop       (tag_pop),
        .flush     (1'b0),
        .occ       (tag_occ),
        .head      (tag_head)
    );

    // Head presentation; all fields forced to zero while the queue is empty
    always_comb begin
        if_parcel            = '0;
        if_parcel_pc         = '0;
        if_parcel_valid      = 2'b00;
        if_parcel_misaligned = 1'b0;
        if_parcel_page_fault = 1'b0;
        if (q_occ != '0) begin
            if_parcel            = q_head.instr;
            if_parcel_pc         = q_head.pc;
            if_parcel_valid      = q_head.pc[1] ? PFQ_VALID_HI : PFQ_VALID_FULL;
            if_parcel_misaligned = q_head.misaligned;
            if_parcel_page_fault = q_head.page_fault;
        end
    end

endmodule
